// File: rtl/star_sched_if.sv
// Star controller bus: position configuration writes and the renderer's
// random-access query port. The controller side uses the slave modport.
interface star_sched_if;
  logic       cfg_we;
  logic [3:0] cfg_idx;
  logic [9:0] cfg_x;
  logic [9:0] cfg_y;
  logic [3:0] rd_idx;
  logic [9:0] rd_x;
  logic [9:0] rd_y;
  logic       rd_en;

  modport master (
    output cfg_we, cfg_idx, cfg_x, cfg_y, rd_idx,
    input  rd_x, rd_y, rd_en
  );

  modport slave (
    input  cfg_we, cfg_idx, cfg_x, cfg_y, rd_idx,
    output rd_x, rd_y, rd_en
  );
endinterface

// File: rtl/star_sched.sv
// star_sched: star-collectible controller. Holds world positions for
// NUM_STARS stars and time-shares a single character/star overlap comparator,
// sweeping one star per clock after each frame tick. Tracks the collected
// bitmap and count, and serves per-star screen position/visibility to the
// renderer through a combinational query port.
// Optional feature: define STAR_RESPAWN_EN to build a frame-tick counter that
// respawns all stars RESPAWN_FRAMES ticks after the last one is collected.
module star_sched #(
  parameter int NUM_STARS      = 8,
  parameter int STAR_SIZE      = 12,
  parameter int CHAR_SIZE      = 12,
  parameter int RESPAWN_FRAMES = 120
) (
  input  logic                 sys_clk,
  input  logic                 RST_N,
  input  logic [9:0]           char_X,
  input  logic [9:0]           char_Y,
  input  logic [9:0]           bg_pos,
  input  logic                 frame_tick,
  input  logic                 level_rst,
  star_sched_if.slave          bus,
  output logic [NUM_STARS-1:0] collected,
  output logic [4:0]           star_count,
  output logic                 collect_pulse,
  output logic [3:0]           collect_idx,
  output logic                 all_collected,
  output logic                 busy,
  output logic                 overrun
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t         state_q, state_d;
  logic [3:0]     idx_q, idx_d;
  logic           start_sweep;
  logic           eval_star;
  logic [9:0]     cx_q, cy_q;
  logic [9:0]     pos_x [NUM_STARS];
  logic [9:0]     pos_y [NUM_STARS];
  logic [9:0]     cur_x, cur_y;
  logic           cur_coll;
  logic [NUM_STARS-1:0] hit_mask;
  logic           overlap;
  logic           hit;
  logic           respawn_hit;

`ifdef STAR_RESPAWN_EN
  logic [15:0]    resp_cnt;

  // Respawn fires on the RESPAWN_FRAMES-th tick seen while every star is collected.
  assign respawn_hit = frame_tick && all_collected && !level_rst &&
                       (resp_cnt == 16'(RESPAWN_FRAMES - 1));

  // Count frame ticks while all stars are collected; restart whenever that ends.
  always_ff @(posedge sys_clk or negedge RST_N) begin
    if (!RST_N) begin
      resp_cnt <= '0;
    end else if (level_rst || !all_collected || respawn_hit) begin
      resp_cnt <= '0;
    end else if (frame_tick) begin
      resp_cnt <= resp_cnt + 16'd1;
    end
  end
`else
  assign respawn_hit = 1'b0;
`endif

  // FSM state, sweep index and latched character position.
  always_ff @(posedge sys_clk or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (start_sweep) begin
        cx_q <= char_X;
        cy_q <= char_Y;
      end
    end
  end

  // Next-state logic; level_rst aborts the sweep and blocks any evaluation.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    start_sweep = 1'b0;
    eval_star   = 1'b0;
    if (level_rst) begin
      state_d = IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (frame_tick && !respawn_hit) begin
            state_d     = SCAN;
            idx_d       = '0;
            start_sweep = 1'b1;
          end
        end
        SCAN: begin
          eval_star = 1'b1;
          if (idx_q == 4'(NUM_STARS - 1)) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Select the star under evaluation for the shared comparator.
  always_comb begin
    cur_x    = '0;
    cur_y    = '0;
    cur_coll = 1'b0;
    hit_mask = '0;
    for (int i = 0; i < NUM_STARS; i++) begin
      if (idx_q == 4'(i)) begin
        cur_x       = pos_x[i];
        cur_y       = pos_y[i];
        cur_coll    = collected[i];
        hit_mask[i] = 1'b1;
      end
    end
  end

  // Box overlap in 11 bits so the size additions never wrap; touching counts.
  assign overlap = ({1'b0, cx_q} + 11'(CHAR_SIZE) >= {1'b0, cur_x}) &&
                   ({1'b0, cx_q} <= {1'b0, cur_x} + 11'(STAR_SIZE)) &&
                   ({1'b0, cy_q} + 11'(CHAR_SIZE) >= {1'b0, cur_y}) &&
                   ({1'b0, cy_q} <= {1'b0, cur_y} + 11'(STAR_SIZE));

  assign hit  = eval_star && overlap && !cur_coll;
  assign busy = (state_q == SCAN);

  // Star position table; writes beyond NUM_STARS match no entry and are dropped.
  always_ff @(posedge sys_clk or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_STARS; i++) begin
        pos_x[i] <= 10'(40 + 48 * i);
        pos_y[i] <= 10'd56;
      end
    end else if (bus.cfg_we) begin
      for (int i = 0; i < NUM_STARS; i++) begin
        if (bus.cfg_idx == 4'(i)) begin
          pos_x[i] <= bus.cfg_x;
          pos_y[i] <= bus.cfg_y;
        end
      end
    end
  end

  // Collection state; level_rst beats both respawn and a same-cycle hit.
  always_ff @(posedge sys_clk or negedge RST_N) begin
    if (!RST_N) begin
      collected     <= '0;
      star_count    <= '0;
      collect_pulse <= 1'b0;
      collect_idx   <= '0;
      all_collected <= 1'b0;
    end else if (level_rst) begin
      collected     <= '0;
      star_count    <= '0;
      collect_pulse <= 1'b0;
      all_collected <= 1'b0;
    end else if (respawn_hit) begin
      collected     <= '0;
      star_count    <= '0;
      collect_pulse <= 1'b0;
      all_collected <= 1'b0;
    end else begin
      collect_pulse <= hit;
      all_collected <= &collected;
      if (hit) begin
        collected   <= collected | hit_mask;
        star_count  <= star_count + 5'd1;
        collect_idx <= idx_q;
      end
    end
  end

  // Sticky flag for a frame tick that lands while a sweep is still running.
  always_ff @(posedge sys_clk or negedge RST_N) begin
    if (!RST_N) begin
      overrun <= 1'b0;
    end else if (frame_tick && state_q == SCAN) begin
      overrun <= 1'b1;
    end
  end

  // Render query: screen x wraps modulo 1024; out-of-range index reads as zero.
  always_comb begin
    bus.rd_x  = '0;
    bus.rd_y  = '0;
    bus.rd_en = 1'b0;
    for (int i = 0; i < NUM_STARS; i++) begin
      if (bus.rd_idx == 4'(i)) begin
        bus.rd_x  = pos_x[i] - bg_pos;
        bus.rd_y  = pos_y[i];
        bus.rd_en = !collected[i];
      end
    end
  end

endmodule

// File: tb/tb_star_sched.sv
// Directed testbench for star_sched: reset values, render query, collection
// timing, corner-touch boundary, overrun, level reset abort and respawn
// (STAR_RESPAWN_EN, exercised with RESPAWN_FRAMES=3).
module tb_star_sched;
  localparam int NS = 8;

  logic          sys_clk = 1'b0;
  logic          RST_N;
  logic [9:0]    char_X, char_Y, bg_pos;
  logic          frame_tick, level_rst;
  logic [NS-1:0] collected;
  logic [4:0]    star_count;
  logic          collect_pulse;
  logic [3:0]    collect_idx;
  logic          all_collected, busy, overrun;

  int compared   = 0;
  int mismatched = 0;
  int pulses;

  star_sched_if bus();

  star_sched #(
    .NUM_STARS(NS), .STAR_SIZE(12), .CHAR_SIZE(12), .RESPAWN_FRAMES(3)
  ) dut (
    .sys_clk(sys_clk), .RST_N(RST_N),
    .char_X(char_X), .char_Y(char_Y), .bg_pos(bg_pos),
    .frame_tick(frame_tick), .level_rst(level_rst),
    .bus(bus),
    .collected(collected), .star_count(star_count),
    .collect_pulse(collect_pulse), .collect_idx(collect_idx),
    .all_collected(all_collected), .busy(busy), .overrun(overrun)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 sys_clk = ~sys_clk;

  // Advance n cycles, landing 1 unit after the rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  // Hold tick/level_rst for the current cycle, then release.
  task automatic apply_stimulus(input logic tick, input logic lrst);
    frame_tick = tick;
    level_rst  = lrst;
    step(1);
    frame_tick = 1'b0;
    level_rst  = 1'b0;
  endtask

  // Compare one observed value against its hand-computed expectation.
  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Run a full sweep from IDLE and count collect pulses it produces.
  task automatic sweep(output int n_pulses);
    n_pulses = 0;
    apply_stimulus(1'b1, 1'b0);
    for (int k = 0; k < NS + 1; k++) begin
      step(1);
      if (collect_pulse === 1'b1) n_pulses++;
    end
  endtask

  // Write one star position through the configuration port.
  task automatic write_star(input logic [3:0] idx, input logic [9:0] x,
                            input logic [9:0] y);
    bus.cfg_we  = 1'b1;
    bus.cfg_idx = idx;
    bus.cfg_x   = x;
    bus.cfg_y   = y;
    step(1);
    bus.cfg_we  = 1'b0;
  endtask

  // Directed test sequence.
  initial begin
    RST_N = 1'b0;
    char_X = '0; char_Y = '0; bg_pos = '0;
    frame_tick = 1'b0; level_rst = 1'b0;
    bus.cfg_we = 1'b0; bus.cfg_idx = '0; bus.cfg_x = '0; bus.cfg_y = '0;
    bus.rd_idx = 4'd2;
    step(3);
    RST_N = 1'b1;
    step(1);

    $display("[TB] reset values and render query");
    check_output("rst_rd_x",      bus.rd_x, 32'd136);
    check_output("rst_rd_y",      bus.rd_y, 32'd56);
    check_output("rst_rd_en",     bus.rd_en, 32'd1);
    check_output("rst_collected", collected, 32'h0);
    check_output("rst_count",     star_count, 32'd0);
    check_output("rst_pulse",     collect_pulse, 32'd0);
    check_output("rst_all",       all_collected, 32'd0);
    check_output("rst_busy",      busy, 32'd0);
    check_output("rst_overrun",   overrun, 32'd0);
    bus.rd_idx = 4'd0; bg_pos = 10'd200;
    #1 check_output("scroll_wrap_x", bus.rd_x, 32'd864);
    bus.rd_idx = 4'd9; bg_pos = 10'd0;
    #1 check_output("oob_rd_x",  bus.rd_x, 32'd0);
    check_output("oob_rd_en", bus.rd_en, 32'd0);

    $display("[TB] collect star 2 at (140,60)");
    bus.rd_idx = 4'd2;
    char_X = 10'd140; char_Y = 10'd60;
    apply_stimulus(1'b1, 1'b0);
    check_output("t1_busy",  busy, 32'd1);
    check_output("t1_pulse", collect_pulse, 32'd0);
    step(2);
    check_output("t3_pulse", collect_pulse, 32'd0);
    step(1);
    check_output("t4_pulse",     collect_pulse, 32'd1);
    check_output("t4_idx",       collect_idx, 32'd2);
    check_output("t4_count",     star_count, 32'd1);
    check_output("t4_collected", collected, 32'h04);
    check_output("t4_rd_en",     bus.rd_en, 32'd0);
    step(1);
    check_output("t5_pulse", collect_pulse, 32'd0);
    step(3);
    check_output("t8_busy", busy, 32'd1);
    step(1);
    check_output("t9_busy", busy, 32'd0);
    check_output("t9_overrun", overrun, 32'd0);
    sweep(pulses);
    check_output("resweep_pulses", pulses, 32'd0);
    check_output("resweep_count",  star_count, 32'd1);

    $display("[TB] configuration writes");
    write_star(4'd3, 10'd300, 10'd200);
    bus.rd_idx = 4'd3;
    #1 check_output("cfg_rd_x", bus.rd_x, 32'd300);
    check_output("cfg_rd_y", bus.rd_y, 32'd200);
    bg_pos = 10'd320;
    #1 check_output("cfg_wrap_x", bus.rd_x, 32'd1004);
    bg_pos = 10'd0;
    write_star(4'd12, 10'd5, 10'd5);
    bus.rd_idx = 4'd12;
    #1 check_output("cfg_oob_x", bus.rd_x, 32'd0);
    check_output("cfg_collected_kept", collected, 32'h04);

    $display("[TB] corner touch boundary");
    apply_stimulus(1'b0, 1'b1);
    check_output("lrst_count", star_count, 32'd0);
    check_output("lrst_collected", collected, 32'h0);
    char_X = 10'd123; char_Y = 10'd44;
    sweep(pulses);
    check_output("miss_pulses", pulses, 32'd0);
    check_output("miss_collected", collected, 32'h0);
    char_X = 10'd124;
    sweep(pulses);
    check_output("touch_pulses", pulses, 32'd1);
    check_output("touch_collected", collected, 32'h04);

    $display("[TB] overrun");
    char_X = 10'd0; char_Y = 10'd0;
    apply_stimulus(1'b1, 1'b0);
    step(2);
    apply_stimulus(1'b1, 1'b0);
    check_output("ovr_flag", overrun, 32'd1);
    check_output("ovr_busy", busy, 32'd1);
    step(4);
    check_output("ovr_t8_busy", busy, 32'd1);
    step(1);
    check_output("ovr_t9_busy", busy, 32'd0);
    check_output("ovr_sticky", overrun, 32'd1);

    $display("[TB] level reset aborts sweep");
    apply_stimulus(1'b0, 1'b1);
    char_X = 10'd140; char_Y = 10'd60;
    apply_stimulus(1'b1, 1'b0);
    step(1);
    apply_stimulus(1'b0, 1'b1);
    check_output("abort_busy",  busy, 32'd0);
    check_output("abort_count", star_count, 32'd0);
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      step(1);
      if (collect_pulse === 1'b1) pulses++;
    end
    check_output("abort_pulses", pulses, 32'd0);
    check_output("abort_collected", collected, 32'h0);

    $display("[TB] collect all and respawn");
    for (int i = 0; i < NS; i++) write_star(4'(i), 10'd500, 10'd300);
    apply_stimulus(1'b0, 1'b1);
    char_X = 10'd500; char_Y = 10'd300;
    sweep(pulses);
    check_output("all_pulses", pulses, 32'd8);
    check_output("all_count", star_count, 32'd8);
    check_output("all_bitmap", collected, 32'hFF);
    check_output("all_flag", all_collected, 32'd1);
    for (int k = 0; k < 2; k++) begin
      apply_stimulus(1'b1, 1'b0);
      step(NS + 1);
    end
    check_output("pre_respawn_bitmap", collected, 32'hFF);
    apply_stimulus(1'b1, 1'b0);
`ifdef STAR_RESPAWN_EN
    check_output("respawn_bitmap", collected, 32'h0);
    check_output("respawn_count",  star_count, 32'd0);
    check_output("respawn_busy",   busy, 32'd0);
    step(2);
    check_output("respawn_all", all_collected, 32'd0);
`else
    check_output("no_respawn_bitmap", collected, 32'hFF);
    check_output("no_respawn_count",  star_count, 32'd8);
    check_output("no_respawn_busy",   busy, 32'd1);
    step(2);
    check_output("no_respawn_all", all_collected, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/star_sched.md
# star_sched

Star-collectible controller for the game-calc layer. Holds world positions for NUM_STARS stars and time-shares one character/star overlap comparator across them, sweeping one star per clock after each frame tick. Tracks which stars are collected and keeps a running count. Serves screen-space position and enable per star to the renderer through a random-access query port, so individual per-star modules with private comparators are not needed.

## Interface
- NUM_STARS, 8: stars managed, 1..16.
- STAR_SIZE, 12: star box edge, pixels.
- CHAR_SIZE, 12: character box edge, pixels.
- RESPAWN_FRAMES, 120: frame ticks before respawn; used only with STAR_RESPAWN_EN.
- sys_clk  in  1  system clock; all state on rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- char_X, char_Y  in  10 each  character top-left, world coordinates.
- bg_pos  in  10  horizontal scroll offset.
- frame_tick  in  1  one-cycle pulse that starts a sweep.
- level_rst  in  1  synchronous clear of collection state.
- cfg_we  in  1  position write strobe.
- cfg_idx  in  4  star index to write.
- cfg_x, cfg_y  in  10 each  star world top-left.
- rd_idx  in  4  render query index.
- rd_x, rd_y  out  10 each  screen x (world x − bg_pos, mod 1024) and world y of star rd_idx; combinational.
- rd_en  out  1  star rd_idx visible (not collected); combinational.
- collected  out  NUM_STARS  bitmap; bit i set once star i is touched.
- star_count  out  5  number of set bits in collected.
- collect_pulse  out  1  one-cycle pulse on a new collection.
- collect_idx  out  4  index for collect_pulse; holds last value.
- all_collected  out  1  collected is all ones.
- busy  out  1  sweep in progress.
- overrun  out  1  sticky; frame_tick arrived while busy.

## Operation
- Reset: positions x_i = 40 + 48·i, y_i = 56. All other outputs are 0 and the FSM is in IDLE.
- FSM has two states.
  - IDLE: on frame_tick (and not level_rst), latch char_X/char_Y, set idx=0, go to SCAN.
  - SCAN: each cycle evaluate star idx. If idx = NUM_STARS−1, go to IDLE; otherwise idx+1.
- Overlap test for star i, all terms 11-bit, no wrap:
  - char_X + CHAR_SIZE ≥ x_i, and char_X ≤ x_i + STAR_SIZE, and
  - char_Y + CHAR_SIZE ≥ y_i, and char_Y ≤ y_i + STAR_SIZE.
  - Touching edges count as overlap.
- Overlap on an uncollected star, in the same cycle:
  - sets collected[i], increments star_count, pulses collect_pulse, loads collect_idx = i.
- Overlap on a collected star has no effect.
- Character coordinates are latched at sweep start, so every star in one sweep sees the same position.
- frame_tick while busy: tick ignored, overrun set. overrun clears only on RST_N.
- level_rst:
  - Clears collected, star_count, all_collected and any respawn timer.
  - Aborts an active sweep to IDLE. Positions are kept.
  - Wins over frame_tick and over a same-cycle collection.
- cfg_we writes x/y of cfg_idx in any state. It does not change collected.
  - A write to the star under evaluation in that cycle takes effect the next cycle; the comparison uses the old value.
  - A write with cfg_idx ≥ NUM_STARS is ignored.
- rd_idx ≥ NUM_STARS: rd_en=0, rd_x=rd_y=0.

## Timing
- frame_tick at cycle T: busy=1 from T+1 through T+NUM_STARS. Star i is evaluated in cycle T+1+i.
- collect_pulse, collected, star_count and collect_idx update at the edge ending cycle T+1+i, visible at T+2+i.
- all_collected is registered; it rises one cycle after the final collected bit is set.
- The next sweep can start at T+NUM_STARS+1. A tick at T+NUM_STARS is an overrun.
- RST_N asserted mid-sweep forces IDLE immediately and applies reset values.

## Configuration
- STAR_RESPAWN_EN defined:
  - While all_collected=1, a counter counts frame_ticks.
  - On tick number RESPAWN_FRAMES it clears collected and star_count in that cycle. No sweep starts on that tick.
- STAR_RESPAWN_EN undefined: no counter is built; stars stay collected until level_rst or RST_N.

## Test plan
- Reset, then rd_idx=2 with bg_pos=0 → rd_x=136, rd_y=56, rd_en=1; all flags 0.
- char at (140,60), frame_tick → collect_pulse 4 cycles after tick with collect_idx=2, star_count=1, collected=0x04. A second sweep gives no pulse.
- char at (124,44) (corner touch of star 2) → collected; char at (123,44) → no collection.
- frame_tick again 3 cycles after a tick, NUM_STARS=8 → overrun=1; the sweep completes normally.
- level_rst one cycle before star 2 would collect → no pulse, star_count=0, busy=0 next cycle.
- STAR_RESPAWN_EN with RESPAWN_FRAMES=3: collect all 8 stars, then 3 ticks → collected=0 after the third tick; with the macro undefined, collected stays 0xFF.
